div_shift_sub: RTL and testbench

Sequential restoring shift-subtract divider. It is the inverse companion of the 16x16->32 Karatsuba multiplier datapath: it takes a 2W-bit dividend and a W-bit divisor and produces a 2W-bit quotient and a W-bit remainder. One quotient bit is resolved per cycle. It uses the same level start/done handshake as the multiplier blocks so control FSMs can drive either block identically.

---
 rtl/div_shift_sub.sv | 146 ++++++++++++++
 tb/tb_div_shift_sub.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_shift_sub.sv
// div_shift_sub: sequential restoring shift-subtract divider.
// Divides a 2W-bit dividend by a W-bit divisor and resolves one quotient bit
// per clock. It uses a level start / done handshake: IDLE -> RUN -> FINISH -> IDLE.
// A zero divisor skips RUN and returns an all-ones quotient with dbz set.
module div_shift_sub #(
   parameter int W  = 16,
   parameter int CW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic [2*W-1:0] quotient,
   output logic [W-1:0]   remainder,
   output logic           dbz,
   output logic           busy,
   output logic           done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_ITER = CW'(2*W-1);

   state_t         r_state;
   state_t         w_state_nxt;

   // Working registers. The partial remainder is always < D after each step,
   // so only its low W bits need storing; the compare itself is W+1 bits wide.
   logic [2*W-1:0] r_n;
   logic [2*W-1:0] r_q;
   logic [W-1:0]   r_d;
   logic [W-1:0]   r_p;
   logic [CW-1:0]  r_cnt;

   // Result registers, updated only on entry into FINISH
   logic [2*W-1:0] r_quot;
   logic [W-1:0]   r_rem;
   logic           r_dbz;

   logic [W:0]     w_t;
   logic [W-1:0]   w_diff;
   logic           w_ge;
   logic [W-1:0]   w_p_nxt;
   logic [2*W-1:0] w_q_nxt;
   logic           w_last;
   logic           w_div_zero;

   // One restoring step: bring down the next dividend bit, then trial-subtract.
   // When T >= D the true difference is < D, so a W-bit subtract is exact.
   assign w_t        = {r_p, r_n[2*W-1]};
   assign w_ge       = (w_t >= {1'b0, r_d});
   assign w_diff     = w_t[W-1:0] - r_d;
   assign w_p_nxt    = w_ge ? w_diff : w_t[W-1:0];
   assign w_q_nxt    = {r_q[2*W-2:0], w_ge};
   assign w_last     = (r_cnt == LAST_ITER);
   assign w_div_zero = (divisor == '0);

   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_FINISH);
   assign quotient  = r_quot;
   assign remainder = r_rem;
   assign dbz       = r_dbz;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; FINISH waits for start to drop so there is no auto-restart
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = w_div_zero ? S_FINISH : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            if (!start) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture in IDLE, one iteration per RUN cycle, result load
   always_ff @(posedge clk) begin
      if (rst) begin
         r_n    <= '0;
         r_q    <= '0;
         r_d    <= '0;
         r_p    <= '0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dbz  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_div_zero) begin
                     r_quot <= '1;
                     r_rem  <= dividend[W-1:0];
                     r_dbz  <= 1'b1;
                  end else begin
                     r_n   <= dividend;
                     r_d   <= divisor;
                     r_p   <= '0;
                     r_q   <= '0;
                     r_cnt <= '0;
                  end
               end
            end
            S_RUN: begin
               r_n   <= {r_n[2*W-2:0], 1'b0};
               r_p   <= w_p_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_quot <= w_q_nxt;
                  r_rem  <= w_p_nxt;
                  r_dbz  <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_shift_sub.sv
// tb_div_shift_sub: directed and random checks of the shift-subtract divider.
module tb_div_shift_sub;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        dbz;
   logic        busy;
   logic        done;

   int n_chk  = 0;
   int n_fail = 0;

   div_shift_sub #(.W(16), .CW(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one operation from IDLE (called at a negedge), wait for done,
   // optionally hold start in FINISH, then drop start and return at a negedge.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic [15:0] er, input logic edbz,
                         input int elat, input int ebusy, input int hold, input bit scramble);
      int cyc;
      int nbusy;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      cyc   = 0;
      nbusy = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (busy) nbusy++;
         if (scramble && cyc == 3) begin
            dividend = $urandom;
            divisor  = 16'($urandom);
         end
      end while (!done && cyc < 100);
      chk({tag, ".latency"}, 64'(cyc), 64'(elat));
      chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(ebusy));
      chk({tag, ".quotient"}, 64'(quotient), 64'(eq));
      chk({tag, ".remainder"}, 64'(remainder), 64'(er));
      chk({tag, ".dbz"}, 64'(dbz), 64'(edbz));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, ".hold_done"}, 64'(done), 64'd1);
         chk({tag, ".hold_quot"}, 64'(quotient), 64'(eq));
         chk({tag, ".hold_rem"}, 64'(remainder), 64'(er));
      end
      start = 1'b0;
      @(negedge clk);
      chk({tag, ".idle_done"}, 64'(done), 64'd0);
      chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
      chk({tag, ".idle_quot"}, 64'(quotient), 64'(eq));
   endtask

   initial begin
      logic [31:0] ra;
      logic [15:0] rb;
      logic [63:0] recon;
      int          cyc;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("reset.quotient", 64'(quotient), 64'd0);
      chk("reset.remainder", 64'(remainder), 64'd0);
      chk("reset.dbz", 64'(dbz), 64'd0);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic divide and extreme / small operands
      run_op("basic", 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 33, 32, 0, 1'b0);
      run_op("max_by_max", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0, 33, 32, 0, 1'b0);
      run_op("max_by_one", 32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000, 1'b0, 33, 32, 0, 1'b0);
      run_op("small", 32'd5, 16'd9, 32'd0, 16'd5, 1'b0, 33, 32, 0, 1'b0);
      run_op("zero_num", 32'd0, 16'd3, 32'd0, 16'd0, 1'b0, 33, 32, 0, 1'b0);

      // Divide by zero: immediate FINISH, busy never high
      run_op("dbz", 32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1, 0, 0, 1'b0);

      // Hold start in FINISH, scramble operands mid-RUN, then a second op
      run_op("hold_iso", 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 33, 32, 5, 1'b1);
      run_op("second", 32'h0000_ABCD, 16'h0100, 32'h0000_00AB, 16'h00CD, 1'b0, 33, 32, 0, 1'b0);

      // Reset mid-operation, with start still high to show rst wins
      dividend = 32'd1000;
      divisor  = 16'd7;
      start    = 1'b1;
      @(posedge clk);
      repeat (10) @(negedge clk);
      chk("midrst.busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst.busy", 64'(busy), 64'd0);
      chk("midrst.done", 64'(done), 64'd0);
      chk("midrst.quotient", 64'(quotient), 64'd0);
      chk("midrst.remainder", 64'(remainder), 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op("after_rst", 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, 33, 32, 0, 1'b0);

      // Random invariant checks
      for (int k = 0; k < 1000; k++) begin
         ra = $urandom;
         rb = 16'($urandom);
         if (rb == 16'd0) rb = 16'd1;
         if (k % 4 == 0) rb = 16'(rb >> $urandom_range(15, 0));
         if (rb == 16'd0) rb = 16'd3;
         dividend = ra;
         divisor  = rb;
         start    = 1'b1;
         @(posedge clk);
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!done && cyc < 100);
         recon = 64'(quotient) * 64'(rb) + 64'(remainder);
         chk("rand.invariant", recon, 64'(ra));
         chk("rand.rem_lt_div", 64'(remainder < rb), 64'd1);
         start = 1'b0;
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
